// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
//   ID/EX pipeline register with a valid/ready handshake. It holds the
//   decoded instruction, PC, PC+4, register-file operands, raw immediate and
//   the packed control bundle for the execute stage. It also handles:
//     - back-pressure from execute (out_ready),
//     - flush of the held and incoming instruction (taken branch),
//     - load-use hazard detection with single-bubble insertion.
//
//   Optional build macro ID_EX_WB_BYPASS_EN:
//     When defined, writeback data presented in the same cycle as a capture
//     replaces a stale register-file operand whose source register matches
//     wb_addr (x0 is never bypassed). When undefined, the wb_* ports are
//     present but ignored.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   in_valid       decode presents a valid instruction
//   in_ready       stage accepts the input this cycle (combinational)
//   in_inst        instruction (rs1=[19:15], rs2=[24:20], rd=[11:7])
//   in_pc          instruction PC
//   in_pc_inc      PC+4
//   in_data_1/2    register-file read data for rs1/rs2
//   in_imm         raw immediate bits inst[31:7]
//   in_ctrl        packed control bundle
//   in_is_load     instruction is a load
//   in_reg_wr_en   instruction writes rd
//   flush          kill held and incoming instruction
//   wb_wr_en       writeback enable
//   wb_addr        writeback destination register
//   wb_data        writeback data
//   out_valid      registered instruction valid
//   out_ready      execute accepts the registered instruction
//   out_inst, out_pc, out_pc_inc, out_data_1, out_data_2   registered copies
//   out_imm        registered immediate
//   out_ctrl       registered control, zero when the stage holds a bubble
//   out_rd         registered destination register
//   out_reg_wr_en  registered write enable, gated by out_valid
//   hazard_stall   load-use stall active this cycle (combinational)
// -----------------------------------------------------------------------------
module id_ex_pipe #(
  parameter int XLEN   = 32,
  parameter int IMM_W  = 25,
  parameter int CTRL_W = 24,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_inst,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_pc_inc,
  input  logic [XLEN-1:0]   in_data_1,
  input  logic [XLEN-1:0]   in_data_2,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_is_load,
  input  logic              in_reg_wr_en,

  input  logic              flush,

  input  logic              wb_wr_en,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [XLEN-1:0]   wb_data,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_inst,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_pc_inc,
  output logic [XLEN-1:0]   out_data_1,
  output logic [XLEN-1:0]   out_data_2,
  output logic [IMM_W-1:0]  out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_reg_wr_en,
  output logic              hazard_stall
);

  // Register fields decoded from the incoming instruction.
  logic [RA_W-1:0] rs1;
  logic [RA_W-1:0] rs2;
  logic [RA_W-1:0] rd_in;

  assign rs1   = in_inst[15 +: RA_W];
  assign rs2   = in_inst[20 +: RA_W];
  assign rd_in = in_inst[7  +: RA_W];

  // Internal state not exposed directly on the output side.
  logic held_is_load;
  logic wr_en_q;

  // The register may take a new value when empty or when execute drains it.
  logic adv;
  logic luh;

  assign adv = !out_valid || out_ready;

  // A held load whose rd feeds the incoming instruction cannot have its data
  // yet; x0 is hard-wired and never creates a dependency.
  assign luh = out_valid && held_is_load && (out_rd != '0) && in_valid &&
               ((out_rd == rs1) || (out_rd == rs2));

  assign hazard_stall  = luh;
  // Under flush the incoming transfer is consumed and discarded.
  assign in_ready      = flush || (adv && !luh);
  assign out_reg_wr_en = out_valid && wr_en_q;

  // Operand selection at capture time.
  logic [XLEN-1:0] data_1_sel;
  logic [XLEN-1:0] data_2_sel;

`ifdef ID_EX_WB_BYPASS_EN
  assign data_1_sel = (wb_wr_en && (wb_addr != '0) && (wb_addr == rs1)) ? wb_data : in_data_1;
  assign data_2_sel = (wb_wr_en && (wb_addr != '0) && (wb_addr == rs2)) ? wb_data : in_data_2;
`else
  assign data_1_sel = in_data_1;
  assign data_2_sel = in_data_2;
  // Writeback ports are part of the interface but have no effect here.
  logic unused_wb;
  assign unused_wb = &{1'b0, wb_wr_en, wb_addr, wb_data};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_inst     <= '0;
      out_pc       <= '0;
      out_pc_inc   <= '0;
      out_data_1   <= '0;
      out_data_2   <= '0;
      out_imm      <= '0;
      out_ctrl     <= '0;
      out_rd       <= '0;
      wr_en_q      <= 1'b0;
      held_is_load <= 1'b0;
    end else if (flush || (adv && luh)) begin
      // Kill or bubble: drop validity and side effects, data fields hold.
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      wr_en_q   <= 1'b0;
    end else if (adv && in_valid) begin
      out_valid    <= 1'b1;
      out_inst     <= in_inst;
      out_pc       <= in_pc;
      out_pc_inc   <= in_pc_inc;
      out_data_1   <= data_1_sel;
      out_data_2   <= data_2_sel;
      out_imm      <= in_imm;
      out_ctrl     <= in_ctrl;
      out_rd       <= rd_in;
      wr_en_q      <= in_reg_wr_en;
      held_is_load <= in_is_load;
    end else if (adv) begin
      // Drained with nothing new: present an empty slot.
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe
//   Self-checking bench for id_ex_pipe. A transaction-level model holds the
//   instruction currently in the stage and advances it by the stage's rules
//   each clock. Directed sequences cover reset, back-pressure, load-use,
//   rd=x0 loads, flush and writeback bypass; a randomized run follows.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe;

  localparam int XLEN   = 32;
  localparam int IMM_W  = 25;
  localparam int CTRL_W = 24;
  localparam int RA_W   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_inst, in_pc, in_pc_inc, in_data_1, in_data_2;
  logic [IMM_W-1:0]  in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_is_load, in_reg_wr_en, flush;
  logic              wb_wr_en;
  logic [RA_W-1:0]   wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_inst, out_pc, out_pc_inc, out_data_1, out_data_2;
  logic [IMM_W-1:0]  out_imm;
  logic [CTRL_W-1:0] out_ctrl;
  logic [RA_W-1:0]   out_rd;
  logic              out_reg_wr_en, hazard_stall;

  id_ex_pipe #(.XLEN(XLEN), .IMM_W(IMM_W), .CTRL_W(CTRL_W), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_pc_inc(in_pc_inc),
    .in_data_1(in_data_1), .in_data_2(in_data_2),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .in_is_load(in_is_load), .in_reg_wr_en(in_reg_wr_en),
    .flush(flush),
    .wb_wr_en(wb_wr_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_pc_inc(out_pc_inc),
    .out_data_1(out_data_1), .out_data_2(out_data_2),
    .out_imm(out_imm), .out_ctrl(out_ctrl), .out_rd(out_rd),
    .out_reg_wr_en(out_reg_wr_en), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  // Instruction currently sitting in the stage, as the model sees it.
  typedef struct {
    logic              valid;
    logic [XLEN-1:0]   inst, pc, pc_inc, d1, d2;
    logic [IMM_W-1:0]  imm;
    logic [CTRL_W-1:0] ctrl;
    logic              wr;
    logic              is_load;
  } xact_t;

  xact_t m;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic xact_t empty_xact();
    xact_t x;
    x.valid = 1'b0; x.inst = '0; x.pc = '0; x.pc_inc = '0; x.d1 = '0; x.d2 = '0;
    x.imm = '0; x.ctrl = '0; x.wr = 1'b0; x.is_load = 1'b0;
    return x;
  endfunction

  // One clock: inputs were set at the negedge; check, predict, advance.
  task automatic step();
    xact_t nx;
    logic [4:0] rs1, rs2, held_rd;
    logic drain, dep;
    #1;
    rs1     = in_inst[19:15];
    rs2     = in_inst[24:20];
    held_rd = m.inst[11:7];
    drain   = !m.valid || out_ready;
    dep     = m.valid && m.is_load && held_rd != 0 && in_valid &&
              (held_rd == rs1 || held_rd == rs2);

    check("out_valid",  out_valid,  m.valid);
    check("out_inst",   out_inst,   m.inst);
    check("out_pc",     out_pc,     m.pc);
    check("out_pc_inc", out_pc_inc, m.pc_inc);
    check("out_data_1", out_data_1, m.d1);
    check("out_data_2", out_data_2, m.d2);
    check("out_imm",    32'(out_imm),  32'(m.imm));
    check("out_ctrl",   32'(out_ctrl), 32'(m.ctrl));
    check("out_rd",     32'(out_rd),   32'(held_rd));
    check("out_reg_wr_en", out_reg_wr_en, m.valid && m.wr);
    check("in_ready",   in_ready, flush || (drain && !dep));
    if (!flush) check("hazard_stall", hazard_stall, dep);

    nx = m;
    if (!reset) nx = empty_xact();
    else if (flush || (drain && dep)) begin
      nx.valid = 1'b0; nx.ctrl = '0; nx.wr = 1'b0;
    end else if (drain && in_valid) begin
      nx.valid = 1'b1; nx.inst = in_inst; nx.pc = in_pc; nx.pc_inc = in_pc_inc;
      nx.d1 = in_data_1; nx.d2 = in_data_2;
`ifdef ID_EX_WB_BYPASS_EN
      if (wb_wr_en && wb_addr != 0 && wb_addr == rs1) nx.d1 = wb_data;
      if (wb_wr_en && wb_addr != 0 && wb_addr == rs2) nx.d2 = wb_data;
`endif
      nx.imm = in_imm; nx.ctrl = in_ctrl; nx.wr = in_reg_wr_en; nx.is_load = in_is_load;
    end else if (drain) begin
      nx.valid = 1'b0; nx.ctrl = '0;
    end
    @(posedge clk);
    m = nx;
    @(negedge clk);
  endtask

  // Present a valid instruction with derived fields and neutral side inputs.
  task automatic present(input logic [31:0] inst, input logic [31:0] pc,
                         input logic is_load, input logic wr);
    in_valid     = 1'b1;
    in_inst      = inst;
    in_pc        = pc;
    in_pc_inc    = pc + 32'd4;
    in_data_1    = pc ^ 32'h1111_0000;
    in_data_2    = pc ^ 32'h0000_2222;
    in_imm       = inst[31:7];
    in_ctrl      = {pc[11:0], inst[11:0]} | 24'h1;
    in_is_load   = is_load;
    in_reg_wr_en = wr;
  endtask

  localparam logic [31:0] ADD_X3   = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] LW_X5    = 32'h0000_A283; // lw  x5,0(x1)
  localparam logic [31:0] ADD_X6_5 = 32'h0022_8333; // add x6,x5,x2
  localparam logic [31:0] LW_X0    = 32'h0000_A003; // lw  x0,0(x1)
  localparam logic [31:0] ADD_X6_0 = 32'h0020_0333; // add x6,x0,x2
  localparam logic [31:0] ADD_X4_3 = 32'h0030_8233; // add x4,x1,x3

  initial begin
    m = empty_xact();
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wb_wr_en = 1'b0; wb_addr = '0; wb_data = '0;
    present(32'h0000_0013, 32'h100, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);

    // Reset held two cycles with a valid input present.
    step();
    step();
    check("rst_ready", in_ready, 1'b1);
    reset = 1'b1;
    step();
    check("first_pc", out_pc, 32'h100);
    check("first_valid", out_valid, 1'b1);

    // Back-pressure.
    present(ADD_X3, 32'h104, 1'b0, 1'b1);
    step();
    present(32'h0000_0093, 32'h108, 1'b0, 1'b1);
    out_ready = 1'b0;
    repeat (3) step();
    check("bp_inst", out_inst, ADD_X3);
    check("bp_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    check("bp_next", out_pc, 32'h108);

    // Load-use: exactly one bubble.
    present(LW_X5, 32'h200, 1'b1, 1'b1);
    step();
    present(ADD_X6_5, 32'h204, 1'b0, 1'b1);
    #1 check("lu_stall", hazard_stall, 1'b1);
    step();
    check("lu_bubble_valid", out_valid, 1'b0);
    check("lu_bubble_ctrl", 32'(out_ctrl), 32'h0);
    check("lu_stall_clear", hazard_stall, 1'b0);
    step();
    check("lu_dep_inst", out_inst, ADD_X6_5);

    // Load to x0: no stall, back-to-back.
    present(LW_X0, 32'h300, 1'b1, 1'b1);
    step();
    present(ADD_X6_0, 32'h304, 1'b0, 1'b1);
    #1 check("x0_no_stall", hazard_stall, 1'b0);
    step();
    check("x0_b2b", out_inst, ADD_X6_0);

    // Flush with a held valid instruction and a valid incoming one.
    present(32'h0041_0513, 32'h400, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", out_valid, 1'b0);
    check("fl_wr_en", out_reg_wr_en, 1'b0);
    check("fl_dropped", out_pc, 32'h304);
    step();

    // Writeback bypass onto rs2.
    present(ADD_X4_3, 32'h500, 1'b0, 1'b1);
    in_data_2 = '0;
    wb_wr_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    step();
    wb_wr_en = 1'b0;
`ifdef ID_EX_WB_BYPASS_EN
    check("bypass_d2", out_data_2, 32'hDEAD_BEEF);
`else
    check("bypass_d2", out_data_2, 32'h0);
`endif

    // Randomized traffic with a narrow register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom;
      t[11:7]  = 5'($urandom_range(0, 3));
      t[19:15] = 5'($urandom_range(0, 3));
      t[24:20] = 5'($urandom_range(0, 3));
      present(t, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 63) != 0);
      wb_wr_en  = 1'($urandom_range(0, 1));
      wb_addr   = 5'($urandom_range(0, 3));
      wb_data   = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
